// File: rtl/arrival_max_accum.sv
// arrival_max_accum: worst-case arrival time over each group of timing arcs driving one output pin,
// with the critical arc's position, arc count and sticky saturation / pin-mismatch flags.
module arrival_max_accum #(
    parameter int W     = 16,
    parameter int FRAC  = 8,
    parameter int ID_W  = 8,
    parameter int CNT_W = 4
) (
    input  logic             CP,
    input  logic             CDN,
    input  logic             arc_valid,
    output logic             arc_ready,
    input  logic [W-1:0]     arc_arrival,
    input  logic [W-1:0]     arc_delay,
    input  logic [ID_W-1:0]  arc_pin_id,
    input  logic             arc_last,
    output logic             at_valid,
    input  logic             at_ready,
    output logic [W-1:0]     at_arrival,
    output logic [ID_W-1:0]  at_pin_id,
    output logic [CNT_W-1:0] at_crit_idx,
    output logic [CNT_W-1:0] at_count,
    output logic             at_ovf,
    output logic             at_pin_err
);
    typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    state_t           state;
    logic [CNT_W-1:0] idx, nidx, ncnt;
    logic [W:0]       raw;
    logic [W-1:0]     sum;
    always_comb begin
        raw  = {1'b0, arc_arrival} + {1'b0, arc_delay};
        sum  = raw[W] ? '1 : raw[W-1:0];
        nidx = (idx == CNT_MAX) ? idx : idx + CNT_W'(1);
        ncnt = (at_count == CNT_MAX) ? at_count : at_count + CNT_W'(1);
    end
    assign arc_ready = (state != EMIT);
    // The accumulators double as the registered result outputs; at_valid qualifies them.
    always_ff @(posedge CP or negedge CDN) begin
        if (!CDN) begin
            state       <= IDLE;
            idx         <= '0;
            at_valid    <= 1'b0;
            at_arrival  <= '0;
            at_pin_id   <= '0;
            at_crit_idx <= '0;
            at_count    <= '0;
            at_ovf      <= 1'b0;
            at_pin_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (arc_valid) begin
                    idx         <= '0;
                    at_arrival  <= sum;
                    at_pin_id   <= arc_pin_id;
                    at_crit_idx <= '0;
                    at_count    <= CNT_W'(1);
                    at_ovf      <= raw[W];
                    at_pin_err  <= 1'b0;
                    at_valid    <= arc_last;
                    state       <= arc_last ? EMIT : ACCUM;
                end
                ACCUM: if (arc_valid) begin
                    idx <= nidx;
                    // Strictly greater: on a tie the earlier arc stays critical.
                    if (sum > at_arrival) begin
                        at_arrival  <= sum;
                        at_crit_idx <= nidx;
                    end
                    at_count   <= ncnt;
                    at_ovf     <= at_ovf | raw[W];
                    at_pin_err <= at_pin_err | (arc_pin_id != at_pin_id);
                    at_valid   <= arc_last;
                    state      <= arc_last ? EMIT : ACCUM;
                end
                EMIT: if (at_ready) begin
                    at_valid <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    a_frac_fits: assert property (@(posedge CP) FRAC <= W);
endmodule
